// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning 4x4 hex keypad decoder with press and release
// debounce. One key is tracked at a time; others are ignored until release.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// SCAN      | drive each row for SCAN_DIV cycles, sample columns on last one
// DEB_PRESS | row frozen, count cycles the captured column pattern is stable
// HELD      | key accepted, watch only the captured column for release
// DEB_REL   | count consecutive open cycles on the captured column
module keypad_scanner #(
    parameter int SCAN_DIV   = 4096,
    parameter int DEB_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_sync,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t          state, state_nx;
    logic [3:0]      row_nx, key_code_nx;
    logic            key_valid_nx, key_held_nx;
    logic [SW-1:0]   scan_cnt, scan_cnt_nx;
    logic [DW-1:0]   deb_cnt, deb_cnt_nx;
    logic [1:0]      cap_r, cap_r_nx, cap_c, cap_c_nx;
    logic [1:0]      row_idx, col_idx;
    logic [3:0]      cap_mask;
    logic            col_onehot, scan_last, deb_done;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign col_onehot = (col_sync != 4'b0000) && ((col_sync & (col_sync - 4'd1)) == 4'b0000);
    assign scan_last  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign deb_done   = (deb_cnt == DW'(DEB_CYCLES));
    assign cap_mask   = 4'b0001 << cap_c;

    // Encode the driven row and the (one-hot) column into indices.
    always_comb begin
        row_idx = 2'd0;
        col_idx = 2'd0;
        case (row)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        case (col_sync)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Next-state and next-output logic for the scan/debounce controller.
    always_comb begin
        state_nx     = state;
        row_nx       = row;
        scan_cnt_nx  = scan_cnt;
        deb_cnt_nx   = deb_cnt;
        cap_r_nx     = cap_r;
        cap_c_nx     = cap_c;
        key_code_nx  = key_code;
        key_valid_nx = 1'b0;
        key_held_nx  = key_held;
        case (state)
            SCAN: begin
                if (!scan_last) begin
                    scan_cnt_nx = scan_cnt + SW'(1);
                end else if (col_onehot) begin
                    // Row stays put so the debounce watches the same key.
                    scan_cnt_nx = '0;
                    cap_r_nx    = row_idx;
                    cap_c_nx    = col_idx;
                    deb_cnt_nx  = '0;
                    state_nx    = DEB_PRESS;
                end else begin
                    scan_cnt_nx = '0;
                    row_nx      = {row[2:0], row[3]};
                end
            end
            DEB_PRESS: begin
                if (deb_done) begin
                    key_code_nx  = key_map(cap_r, cap_c);
                    key_valid_nx = 1'b1;
                    key_held_nx  = 1'b1;
                    state_nx     = HELD;
                end else if (col_sync == cap_mask) begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end else begin
                    scan_cnt_nx = '0;
                    state_nx    = SCAN;
                end
            end
            HELD: begin
                if (!col_sync[cap_c]) begin
                    deb_cnt_nx = '0;
                    state_nx   = DEB_REL;
                end
            end
            DEB_REL: begin
                if (col_sync[cap_c]) begin
                    state_nx = HELD;
                end else if (deb_done) begin
                    key_held_nx = 1'b0;
                    row_nx      = {row[2:0], row[3]};
                    scan_cnt_nx = '0;
                    state_nx    = SCAN;
                end else begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row       <= 4'b0001;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            cap_r     <= 2'd0;
            cap_c     <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            row       <= row_nx;
            scan_cnt  <= scan_cnt_nx;
            deb_cnt   <= deb_cnt_nx;
            cap_r     <= cap_r_nx;
            cap_c     <= cap_c_nx;
            key_code  <= key_code_nx;
            key_valid <= key_valid_nx;
            key_held  <= key_held_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEB_CYCLES=8.
// Edge numbering: edge 1 is the first rising edge after reset is released.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] col_sync;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks;
    int errors;
    int edge_n;
    int pulses;
    int last_pulse;
    logic prev_valid;

    typedef struct {
        logic [3:0] col;
        logic [3:0] row;
        logic [3:0] code;
        logic       valid;
        logic       held;
    } vec_t;

    vec_t vecs[36];

    keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .col_sync(col_sync),
        .row(row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // One clock with the given columns; sampled on the following falling edge.
    task automatic step(input logic [3:0] c);
        col_sync = c;
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        if (key_valid === 1'b1) begin
            pulses++;
            last_pulse = edge_n;
        end
        chk("row_onehot", 32'($countones(row) == 1), 32'd1);
        chk("valid_twice", 32'(key_valid && prev_valid), 32'd0);
        prev_valid = key_valid;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        col_sync = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row", 32'(row), 32'h1);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        reset      = 1'b1;
        edge_n     = 0;
        pulses     = 0;
        last_pulse = 0;
        prev_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        edge_n     = 0;
        pulses     = 0;
        last_pulse = 0;
        prev_valid = 1'b0;
        reset      = 1'b0;
        col_sync   = 4'b0000;

        // Idle scan for edges 1..20, then key 5 held from edge 21:
        // sample at edge 24, accept at edge 33.
        for (int k = 1; k <= 20; k++) begin
            vecs[k-1] = '{4'b0000, 4'(1 << ((k / 4) % 4)), 4'h0, 1'b0, 1'b0};
        end
        for (int k = 21; k <= 32; k++) begin
            vecs[k-1] = '{4'b0010, 4'b0010, 4'h0, 1'b0, 1'b0};
        end
        vecs[32] = '{4'b0010, 4'b0010, 4'h5, 1'b1, 1'b1};
        for (int k = 34; k <= 36; k++) begin
            vecs[k-1] = '{4'b0010, 4'b0010, 4'h5, 1'b0, 1'b1};
        end

        do_reset();
        for (int i = 0; i < 36; i++) begin
            step(vecs[i].col);
            chk($sformatf("vecA[%0d].row", i), 32'(row), 32'(vecs[i].row));
            chk($sformatf("vecA[%0d].code", i), 32'(key_code), 32'(vecs[i].code));
            chk($sformatf("vecA[%0d].valid", i), 32'(key_valid), 32'(vecs[i].valid));
            chk($sformatf("vecA[%0d].held", i), 32'(key_held), 32'(vecs[i].held));
        end

        // Press glitch: sample at edge 8, drop at debounce cycle 4 (edge 12).
        do_reset();
        repeat (4) step(4'b0000);
        repeat (4) step(4'b0010);
        repeat (3) step(4'b0010);
        step(4'b0000);
        chk("glitch_row", 32'(row), 32'h2);
        chk("glitch_held", 32'(key_held), 32'h0);
        chk("glitch_pulses", 32'(pulses), 32'd0);
        // Stable press: resample at edge 16, accept at edge 25.
        repeat (13) step(4'b0010);
        chk("press5_pulses", 32'(pulses), 32'd1);
        chk("press5_edge", 32'(last_pulse), 32'd25);
        chk("press5_code", 32'(key_code), 32'h5);
        chk("press5_held", 32'(key_held), 32'h1);

        // Release glitch of 3 cycles in HELD, then full release.
        repeat (2) step(4'b0010);
        repeat (3) step(4'b0000);
        repeat (4) step(4'b0010);
        chk("relglitch_pulses", 32'(pulses), 32'd1);
        chk("relglitch_held", 32'(key_held), 32'h1);
        chk("relglitch_row", 32'(row), 32'h2);
        repeat (9) step(4'b0000);
        chk("rel_held_early", 32'(key_held), 32'h1);
        step(4'b0000);
        chk("rel_held", 32'(key_held), 32'h0);
        chk("rel_row", 32'(row), 32'h4);
        chk("rel_code", 32'(key_code), 32'h5);
        chk("rel_pulses", 32'(pulses), 32'd1);

        // Key 7 on row 0100 (sample at edge 48), reset at debounce cycle 5.
        repeat (3) step(4'b0000);
        repeat (5) step(4'b0001);
        reset = 1'b0;
        step(4'b0001);
        reset = 1'b1;
        chk("midrst_row", 32'(row), 32'h1);
        chk("midrst_held", 32'(key_held), 32'h0);
        chk("midrst_valid", 32'(key_valid), 32'h0);
        chk("midrst_code", 32'(key_code), 32'h0);
        repeat (20) step(4'b0000);
        chk("midrst_pulses", 32'(pulses), 32'd1);
        chk("midrst_code_after", 32'(key_code), 32'h0);

        // Multi-hot ignored on row 0001, then key D on row 1000.
        do_reset();
        repeat (4) step(4'b0011);
        chk("multihot_row", 32'(row), 32'h2);
        chk("multihot_held", 32'(key_held), 32'h0);
        repeat (8) step(4'b0000);
        chk("keyd_row_pre", 32'(row), 32'h8);
        repeat (13) step(4'b1000);
        chk("keyd_pulses", 32'(pulses), 32'd1);
        chk("keyd_edge", 32'(last_pulse), 32'd25);
        chk("keyd_code", 32'(key_code), 32'hD);
        chk("keyd_held", 32'(key_held), 32'h1);
        chk("keyd_row", 32'(row), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Consumes the synchronized 4-bit column bus from the column synchronizer and drives the 4 keypad row lines.
- Scans a 4x4 hex keypad one row at a time, debounces both press and release, and emits a 4-bit hex key code with a one-cycle valid strobe.
- Feeds the downstream key-history / display logic.
- Exactly one key is tracked at a time; all other keys are ignored until it is released.

Parameters:
- SCAN_DIV, 4096, clk cycles each row is driven during scanning (>=2).
- DEB_CYCLES, 240000, consecutive stable cycles needed to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- col_sync  input  4  synchronized columns; bit=1 means a key in that column on the driven row is closed.
- row  output  4  one-hot, active-high row drive.
- key_code  output  4  hex value of last accepted key; holds until the next accepted press.
- key_valid  output  1  one-cycle pulse on each accepted press.
- key_held  output  1  high from accepted press until accepted release.

Behaviour:
- Reset (reset=0 at posedge clk):
  - state=SCAN, row=4'b0001, key_code=0, key_valid=0, key_held=0.
  - All counters and captured indices = 0.
  - Takes priority over every state, including mid-debounce.
- Key map (row index r = row bit set, col index c = col bit set):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - c0 is the leftmost entry in each row.
- Counters: scan counter counts 0..SCAN_DIV-1; debounce counter counts 0..DEB_CYCLES. Widths are $clog2 of the maximum value +1. Neither counter overflows.
- SCAN:
  - Scan counter increments each cycle.
  - Sampling happens only when the count equals SCAN_DIV-1, the last dwell cycle, which gives row settling time.
  - If col_sync at the sample is exactly one-hot: capture r and c, clear the debounce counter, and go to DEB_PRESS. row does not advance.
  - If col_sync is 0 or multi-hot: ignore it. On the next edge, row rotates left (4'b1000 -> 4'b0001) and the scan counter returns to 0.
- DEB_PRESS (row frozen):
  - Each cycle that col_sync equals the captured one-hot: increment the counter.
  - Any mismatch: go back to SCAN on the same row with the scan counter reset to 0; no output change.
  - When the counter reaches DEB_CYCLES: key_code <= map(r,c), key_valid=1 for exactly that next cycle, key_held=1, go to HELD.
  - Latency: capture at cycle C0, matches at C0+1..C0+DEB_CYCLES, key_valid high at C0+DEB_CYCLES+1.
- HELD (row frozen):
  - Only col_sync[c] is watched; other column bits are don't-care.
  - col_sync[c]=0: go to DEB_REL with the counter cleared.
- DEB_REL:
  - Count consecutive cycles with col_sync[c]=0.
  - col_sync[c]=1 before DEB_CYCLES: return to HELD. No new key_valid; key_held stays 1.
  - DEB_CYCLES consecutive zeros: key_held=0, go to SCAN, row advances to the next row, scan counter 0.
- Invariants:
  - key_valid is never high in two consecutive cycles.
  - key_valid is never high outside the DEB_PRESS->HELD transition.
  - row is always exactly one-hot.

Test Plan:
All tests use SCAN_DIV=4 and DEB_CYCLES=8.
- Reset then idle (col_sync=0) -> row=0001,0010,0100,1000,0001, each held for 4 cycles; key_code=0, key_valid=0, key_held=0.
- Hold col_sync=0010 whenever row=0010 (key 5) -> exactly one key_valid pulse 9 cycles after the sample; key_code=4'h5; key_held=1; row stays 0010.
- Press key 5 but drop col_sync to 0000 for 1 cycle at debounce cycle 4 -> no pulse, SCAN resumes on row 0010. A subsequent stable press -> one pulse, key_code=5.
- In HELD, drop col_sync for 3 cycles then restore -> no second pulse, key_held=1. Then release for 8+ cycles -> key_held=0, row advances to 0100, key_code stays 5.
- col_sync=0011 at row=0001 sample -> ignored, scanning continues. Key D (row 1000, col 1000) -> key_code=4'hD.
- Assert reset at debounce cycle 5 -> next edge: row=0001, key_held=0, key_valid=0, key_code=0, and no pulse follows.
